// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sorter types and default widths
// Purpose: default address/data widths and the input-stage state encoding,
//   shared by the input stage and the sort control FSM.
// Ports: none (package).
package sort_pkg;

  localparam int SORT_AWIDTH = 4;
  localparam int SORT_DWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    RECV_S = 2'd1,
    WAIT_S = 2'd2,
    DROP_S = 2'd3
  } in_state_t;

endpackage

// File: rtl/sort_input_ctrl.sv
// rtl/sort_input_ctrl.sv - sorter input stage: packet sink to sort RAM writer
// Purpose: accepts one packet per sort job, writes its words to RAM
//   addresses 0..N-1 and hands the job to the control FSM through the
//   falling edge of wren_o, with cntr_o = N-1. Holds off packets while the
//   sorter is busy, truncates oversize packets and flags framing errors.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   snk_*_i / snk_ready_o packet sink (data, sop, eop, valid / ready)
//   busy_i                sorter busy from the control FSM
//   mem_we_o/addr_o/data_o RAM write port (one cycle behind the transfer)
//   wren_o                high while the packet is written
//   cntr_o                index of the last written word
//   err_o                 one-cycle framing/truncation error pulse
module sort_input_ctrl
  import sort_pkg::*;
#(
  parameter int AWIDTH = SORT_AWIDTH,
  parameter int DWIDTH = SORT_DWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_sop_i,
  input  logic              snk_eop_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  input  logic              busy_i,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              wren_o,
  output logic [AWIDTH-1:0] cntr_o,
  output logic              err_o
);

  // One more bit than the address so the "RAM full" compare cannot wrap.
  localparam logic [AWIDTH:0] MAX_WORDS = {1'b1, {AWIDTH{1'b0}}};

  in_state_t         state_q, state_d;
  logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic              trunc_q, trunc_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic [AWIDTH-1:0] cntr_q, cntr_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              start_pkt;

  // Ready is gated by reset so it reads 0 while reset is held.
  always_comb begin
    snk_ready_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE_S:  snk_ready_o = ~busy_i;
        RECV_S:  snk_ready_o = 1'b1;
        DROP_S:  snk_ready_o = 1'b1;
        default: snk_ready_o = 1'b0;
      endcase
    end
  end

  assign xfer = snk_valid_i & snk_ready_o;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    trunc_d   = trunc_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cntr_d    = cntr_q;
    err_d     = 1'b0;
    start_pkt = 1'b0;

    case (state_q)
      IDLE_S: begin
        if (xfer) begin
          if (snk_sop_i) start_pkt = 1'b1;
          else           err_d     = 1'b1;
        end
      end
      RECV_S: begin
        if (xfer) begin
          if (snk_sop_i) begin
            // New packet header mid-packet: restart from address 0.
            err_d     = 1'b1;
            start_pkt = 1'b1;
          end else if (wr_ptr_q == MAX_WORDS) begin
            // RAM full: close the job with what fits, discard the rest.
            err_d   = 1'b1;
            cntr_d  = '1;
            trunc_d = 1'b1;
            state_d = snk_eop_i ? WAIT_S : DROP_S;
          end else begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q[AWIDTH-1:0];
            data_d   = snk_data_i;
            wr_ptr_d = wr_ptr_q + (AWIDTH+1)'(1);
            if (snk_eop_i) begin
              cntr_d  = wr_ptr_q[AWIDTH-1:0];
              state_d = WAIT_S;
            end
          end
        end
      end
      DROP_S: begin
        if (xfer && snk_eop_i) begin
          state_d = trunc_q ? WAIT_S : IDLE_S;
          trunc_d = 1'b0;
        end
      end
      WAIT_S: begin
        if (busy_i) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase

    if (start_pkt) begin
      we_d     = 1'b1;
      addr_d   = '0;
      data_d   = snk_data_i;
      wr_ptr_d = (AWIDTH+1)'(1);
      trunc_d  = 1'b0;
      if (snk_eop_i) begin
        cntr_d  = '0;
        state_d = WAIT_S;
      end else begin
        state_d = RECV_S;
      end
    end
  end

  // wren covers every cycle a packet word is being written, so it falls
  // together with the last RAM write (a single-word packet gives one cycle).
  assign wren_d = we_d | (state_d == RECV_S);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE_S;
      wr_ptr_q <= '0;
      trunc_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      cntr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      trunc_q  <= trunc_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      cntr_q   <= cntr_d;
      err_q    <= err_d;
    end
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign wren_o     = wren_q;
  assign cntr_o     = cntr_q;
  assign err_o      = err_q;

endmodule
